uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_bit_timer.sv | 52 +++++
 rtl/uart_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_tx.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths: FSM state
// encodings, frame line levels, the latched frame payload and the parity rule.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STATE_W   = 3;

    // State encodings, kept as plain constants so the receiver can reuse them
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } uart_state_e;

    // Line levels; the idle line sits at the stop level
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Byte captured at accept plus its precomputed parity bit
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 parity;
    } uart_frame_t;

    // Even parity: the returned bit makes the total count of ones even
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ----------------------------------------------------------------------------
// uart_bit_timer
// Bit-period divider. Counts system clocks while running and flags the final
// clock of every CLKS_PER_BIT-long bit. Held at zero while idle, so there is
// no free-running tick between frames.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      synchronous active-low reset
//   i_clear      restart the count at zero (frame accept)
//   i_run        count while high; counter parked at zero when low
//   o_bit_end_c  high on the last clock of the current bit
//   o_pre_end_c  high on the second-to-last clock of the current bit
// ----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_bit_end_c,
    output logic o_pre_end_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);

    // Clock counter: wraps at the bit boundary
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_run) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_bit_end_c = i_run && w_last;
    // Lets the parent register a pulse that lands exactly on the last clock
    assign o_pre_end_c = i_run && (r_cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
// Serial transmitter. Frame: start(0), 8 data bits LSB first, optional even
// parity bit, stop(1). Each bit lasts CLKS_PER_BIT system clocks.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      synchronous active-low reset
//   i_tx_enable  gate for accepting new bytes (frame in flight still completes)
//   i_tx_data    byte to send, sampled on the accept cycle only
//   i_tx_valid   producer offers i_tx_data
//   o_tx_ready   a byte can be accepted this cycle
//   o_tx         serial line, idles high
//   o_tx_busy    a frame is on the line
//   o_tx_done    one-clock pulse on the final clock of the stop bit
// ----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_enable,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e          r_state;
    uart_state_e          w_state_next;
    uart_frame_t          r_frame;
    uart_frame_t          w_frame_next;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic [BIT_IDX_W-1:0] w_bit_idx_next;

    logic r_tx;
    logic r_busy;
    logic r_ready;
    logic r_done;
    logic w_tx_next;
    logic w_busy_next;
    logic w_ready_next;
    logic w_done_next;

    logic w_accept;
    logic w_run;
    logic w_bit_end;
    logic w_pre_end;

    assign w_accept = i_tx_valid && r_ready && (r_state == S_IDLE);
    assign w_run    = (r_state != S_IDLE);

    // Bit-period divider, restarted on every accepted byte
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_accept),
        .i_run       (w_run),
        .o_bit_end_c (w_bit_end),
        .o_pre_end_c (w_pre_end)
    );

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_bit_idx <= '0;
            r_tx      <= STOP_LEVEL;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_frame   <= w_frame_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_ready   <= w_ready_next;
            r_done    <= w_done_next;
        end
    end

    // Next-state, shift register and registered-output decode
    always_comb begin
        w_state_next   = r_state;
        w_frame_next   = r_frame;
        w_bit_idx_next = r_bit_idx;
        w_tx_next      = STOP_LEVEL;
        w_busy_next    = 1'b0;
        w_ready_next   = 1'b0;
        w_done_next    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next        = S_START;
                    w_frame_next.data   = i_tx_data;
                    w_frame_next.parity = even_parity(i_tx_data);
                    w_bit_idx_next      = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_frame_next.data = r_frame.data >> 1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_bit_idx_next = '0;
                        if (PARITY_EN) begin
                            w_state_next = S_PARITY;
                        end else begin
                            w_state_next = S_STOP;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + BIT_IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Line level registered for the state being entered
        unique case (w_state_next)
            S_START:  w_tx_next = START_LEVEL;
            S_DATA:   w_tx_next = w_frame_next.data[0];
            S_PARITY: w_tx_next = w_frame_next.parity;
            default:  w_tx_next = STOP_LEVEL;
        endcase

        w_busy_next  = (w_state_next != S_IDLE);
        // Based on the current state, so ready lags the return to IDLE by one clock
        w_ready_next = (r_state == S_IDLE) && i_tx_enable && !w_accept;
        // Registered one clock early so the pulse sits on the last stop clock
        w_done_next  = (r_state == S_STOP) && w_pre_end;
    end

    assign o_tx       = r_tx;
    assign o_tx_busy  = r_busy;
    assign o_tx_ready = r_ready;
    assign o_tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int N     = 16;
    localparam int N2    = 2;
    localparam int FRAME = 11 * N;
    localparam int RECSZ = 512;

    logic       clk;
    logic       rst_n;
    logic       tx_enable, tx_valid, tx_ready, tx, tx_busy, tx_done;
    logic [7:0] tx_data;
    logic       tx_enable2, tx_valid2, tx_ready2, tx2, tx_busy2, tx_done2;
    logic [7:0] tx_data2;

    int total = 0;
    int bad   = 0;

    logic rec_tx    [RECSZ];
    logic rec_busy  [RECSZ];
    logic rec_ready [RECSZ];
    int   rec_ndone;
    int   rec_done_pos;

    // behavioural receiver state
    bit         rx_on = 1'b0;
    logic       rx_prev;
    logic [7:0] rx_q [$];
    int         rx_frames = 0;
    int         rx_err = 0;

    uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tx_enable (tx_enable),
        .i_tx_data   (tx_data),
        .i_tx_valid  (tx_valid),
        .o_tx_ready  (tx_ready),
        .o_tx        (tx),
        .o_tx_busy   (tx_busy),
        .o_tx_done   (tx_done)
    );

    uart_tx #(.CLKS_PER_BIT(N2), .PARITY_EN(1'b0)) u_dut2 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tx_enable (tx_enable2),
        .i_tx_data   (tx_data2),
        .i_tx_valid  (tx_valid2),
        .o_tx_ready  (tx_ready2),
        .o_tx        (tx2),
        .o_tx_busy   (tx_busy2),
        .o_tx_done   (tx_done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int ones(input logic [7:0] b);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(b[i]);
        return c;
    endfunction

    // Line level k clocks after the accept edge (k=1 is the first start clock)
    function automatic logic exp_line(input logic [7:0] b, input int k, input int n, input bit par);
        int pos;
        logic [7:0] sh;
        if (k < 1) return 1'b1;
        pos = (k - 1) / n;
        if (pos == 0) return 1'b0;
        if (pos <= 8) begin
            sh = b >> (pos - 1);
            return sh[0];
        end
        if (par && pos == 9) return 1'(ones(b) % 2);
        return 1'b1;
    endfunction

    function automatic int frame_errs(input logic [7:0] b, input int ncyc);
        int e = 0;
        for (int k = 1; k <= ncyc; k++)
            if (rec_tx[k] !== exp_line(b, k, N, 1'b1)) e++;
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit to);
        for (int i = 0; i < 64 && tx_ready !== 1'b1; i++) tick();
        to = (tx_ready !== 1'b1);
    endtask

    // Leaves the bench at clock 1 of the new frame
    task automatic start_frame(input logic [7:0] b, output bit to);
        wait_ready(to);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
    endtask

    // Records ncyc clocks; optionally drops tx_enable and raises tx_valid at clock dis_at
    task automatic record_frame(input int ncyc, input int dis_at);
        rec_ndone = 0;
        rec_done_pos = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k == dis_at) begin
                tx_enable = 1'b0;
                tx_valid  = 1'b1;
                tx_data   = 8'h99;
            end
            rec_tx[k]    = tx;
            rec_busy[k]  = tx_busy;
            rec_ready[k] = tx_ready;
            if (tx_done === 1'b1) begin
                rec_ndone++;
                rec_done_pos = k;
            end
            tick();
        end
    endtask

    // ---------------- behavioural receiver ----------------
    initial begin
        logic [7:0] d;
        logic       s0, p, s1;
        rx_prev = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rx_on && rx_prev === 1'b1 && tx === 1'b0) begin
                for (int i = 0; i < N / 2; i++) begin @(posedge clk); #2; end
                s0 = tx;
                for (int j = 0; j < 8; j++) begin
                    for (int i = 0; i < N; i++) begin @(posedge clk); #2; end
                    d[j] = tx;
                end
                for (int i = 0; i < N; i++) begin @(posedge clk); #2; end
                p = tx;
                for (int i = 0; i < N; i++) begin @(posedge clk); #2; end
                s1 = tx;
                if (s0 !== 1'b0 || s1 !== 1'b1 || p !== 1'(ones(d) % 2)) rx_err++;
                rx_q.push_back(d);
                rx_frames++;
                rx_prev = s1;
            end else begin
                rx_prev = tx;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tx_enable = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        tx_enable2 = 1'b1; tx_valid2 = 1'b0; tx_data2 = 8'h00;
        repeat (3) tick();
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", tx_ready); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", tx_done); end
        rst_n = 1'b1;
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL ready_first_cycle got=%b exp=0", tx_ready); end
        tick();
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL ready_rise got=%b exp=1", tx_ready); end
    endtask

    task automatic test_single_a5();
        bit to;
        logic pat [11];
        int e;
        pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        start_frame(8'hA5, to);
        total++; if (to) begin bad++; $display("FAIL a5_accept_timeout got=1 exp=0"); end
        record_frame(FRAME + 3, 0);
        for (int j = 0; j < 11; j++) begin
            total++;
            if (rec_tx[1 + j * N + N / 2] !== pat[j]) begin
                bad++; $display("FAIL a5_bit%0d got=%b exp=%b", j, rec_tx[1 + j * N + N / 2], pat[j]);
            end
        end
        e = frame_errs(8'hA5, FRAME + 3);
        total++; if (e != 0) begin bad++; $display("FAIL a5_line_cycles got=%0d bad clocks exp=0", e); end
        total++; if (rec_ndone != 1) begin bad++; $display("FAIL a5_done_count got=%0d exp=1", rec_ndone); end
        total++; if (rec_done_pos != FRAME) begin bad++; $display("FAIL a5_done_clock got=%0d exp=%0d", rec_done_pos, FRAME); end
        total++; if (rec_busy[1] !== 1'b1) begin bad++; $display("FAIL a5_busy_start got=%b exp=1", rec_busy[1]); end
        total++; if (rec_busy[FRAME + 1] !== 1'b0) begin bad++; $display("FAIL a5_busy_end got=%b exp=0", rec_busy[FRAME + 1]); end
        total++; if (rec_ready[FRAME + 1] !== 1'b0) begin bad++; $display("FAIL a5_ready_after_done got=%b exp=0", rec_ready[FRAME + 1]); end
        total++; if (rec_ready[FRAME + 2] !== 1'b1) begin bad++; $display("FAIL a5_ready_return got=%b exp=1", rec_ready[FRAME + 2]); end
    endtask

    task automatic test_parity();
        bit to;
        logic [7:0] b;
        logic ep;
        int e;
        for (int t = 0; t < 8; t++) begin
            case (t)
                0: b = 8'h01;
                1: b = 8'h00;
                2: b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            ep = 1'(ones(b) % 2);
            start_frame(b, to);
            total++; if (to) begin bad++; $display("FAIL par_accept_timeout byte=%h", b); end
            record_frame(FRAME + 3, 0);
            total++;
            if (rec_tx[1 + 9 * N + N / 2] !== ep) begin
                bad++; $display("FAIL parity_bit byte=%h got=%b exp=%b", b, rec_tx[1 + 9 * N + N / 2], ep);
            end
            e = frame_errs(b, FRAME + 3);
            total++; if (e != 0) begin bad++; $display("FAIL par_line byte=%h got=%0d bad clocks exp=0", b, e); end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        bit pend;
        int e = 0;
        int nd = 0;
        int dp1 = 0;
        int dp2 = 0;
        int naccept = 1;
        logic ex;
        wait_ready(to);
        total++; if (to) begin bad++; $display("FAIL b2b_ready_timeout got=1 exp=0"); end
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tick();
        tx_data  = 8'h81;
        for (int k = 1; k <= 2 * FRAME + 8; k++) begin
            ex = (k <= FRAME + 2) ? exp_line(8'h3C, k, N, 1'b1)
                                  : exp_line(8'h81, k - (FRAME + 2), N, 1'b1);
            if (tx !== ex) e++;
            if (tx_done === 1'b1) begin
                nd++;
                if (nd == 1) dp1 = k; else dp2 = k;
            end
            pend = (tx_ready === 1'b1) && tx_valid;
            tick();
            if (pend) begin
                naccept++;
                tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        total++; if (e != 0) begin bad++; $display("FAIL b2b_line got=%0d bad clocks exp=0", e); end
        total++; if (nd != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
        total++; if (dp1 != FRAME) begin bad++; $display("FAIL b2b_done1 got=%0d exp=%0d", dp1, FRAME); end
        total++; if (dp2 != 2 * FRAME + 2) begin bad++; $display("FAIL b2b_done2 got=%0d exp=%0d", dp2, 2 * FRAME + 2); end
        total++; if (naccept != 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", naccept); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int nd = 0;
        int e;
        start_frame(8'hF0, to);
        total++; if (to) begin bad++; $display("FAIL rstmid_accept_timeout got=1 exp=0"); end
        repeat (4 * N + N / 2 - 1) tick();
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL rstmid_bit3 got=%b exp=0", tx); end
        rst_n = 1'b0;
        tick();
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", tx_busy); end
        if (tx_done === 1'b1) nd++;
        rst_n = 1'b1;
        for (int k = 0; k < 3 * N; k++) begin
            if (tx_done === 1'b1) nd++;
            tick();
        end
        total++; if (nd != 0) begin bad++; $display("FAIL rstmid_done got=%0d pulses exp=0", nd); end
        start_frame(8'h55, to);
        total++; if (to) begin bad++; $display("FAIL rstmid_55_timeout got=1 exp=0"); end
        record_frame(FRAME + 3, 0);
        e = frame_errs(8'h55, FRAME + 3);
        total++; if (e != 0) begin bad++; $display("FAIL rstmid_55_line got=%0d bad clocks exp=0", e); end
        total++; if (rec_done_pos != FRAME) begin bad++; $display("FAIL rstmid_55_done got=%0d exp=%0d", rec_done_pos, FRAME); end
    endtask

    task automatic test_enable();
        bit to;
        int e;
        int nr = 0;
        start_frame(8'hC3, to);
        total++; if (to) begin bad++; $display("FAIL en_accept_timeout got=1 exp=0"); end
        record_frame(FRAME + 20, 9 * N + N / 2);
        e = frame_errs(8'hC3, FRAME + 20);
        total++; if (e != 0) begin bad++; $display("FAIL en_line got=%0d bad clocks exp=0", e); end
        total++; if (rec_ndone != 1) begin bad++; $display("FAIL en_done_count got=%0d exp=1", rec_ndone); end
        for (int k = FRAME + 1; k <= FRAME + 20; k++) if (rec_ready[k] !== 1'b0) nr++;
        total++; if (nr != 0) begin bad++; $display("FAIL en_ready_held got=%0d ready clocks exp=0", nr); end
        tx_enable = 1'b1;
        tick();
        tick();
        tx_valid = 1'b0;
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL en_reaccept got=%b exp=1", tx_busy); end
        record_frame(FRAME + 3, 0);
        e = frame_errs(8'h99, FRAME + 3);
        total++; if (e != 0) begin bad++; $display("FAIL en_99_line got=%0d bad clocks exp=0", e); end
    endtask

    task automatic test_no_parity();
        logic [7:0] b;
        int e;
        int nd;
        int dp;
        for (int t = 0; t < 6; t++) begin
            b = (t == 0) ? 8'h01 : 8'($urandom);
            for (int i = 0; i < 64 && tx_ready2 !== 1'b1; i++) tick();
            total++; if (tx_ready2 !== 1'b1) begin bad++; $display("FAIL np_ready got=%b exp=1", tx_ready2); end
            tx_valid2 = 1'b1;
            tx_data2  = b;
            tick();
            tx_valid2 = 1'b0;
            e = 0; nd = 0; dp = 0;
            for (int k = 1; k <= 10 * N2 + 3; k++) begin
                if (tx2 !== exp_line(b, k, N2, 1'b0)) e++;
                if (tx_done2 === 1'b1) begin nd++; dp = k; end
                tick();
            end
            total++; if (e != 0) begin bad++; $display("FAIL np_line byte=%h got=%0d bad clocks exp=0", b, e); end
            total++; if (nd != 1 || dp != 10 * N2) begin
                bad++; $display("FAIL np_done byte=%h got=%0d pulses at %0d exp=1 at %0d", b, nd, dp, 10 * N2);
            end
        end
    endtask

    task automatic test_loopback();
        bit to;
        bit pend;
        int idx = 0;
        int cyc = 0;
        int nd = 0;
        int nbad = 0;
        rx_q.delete();
        rx_frames = 0;
        rx_err = 0;
        wait_ready(to);
        total++; if (to) begin bad++; $display("FAIL lb_ready_timeout got=1 exp=0"); end
        rx_on = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        while (idx < 256 && cyc < 256 * (FRAME + 2) + 200) begin
            if (tx_done === 1'b1) nd++;
            pend = (tx_ready === 1'b1) && tx_valid;
            tick();
            cyc++;
            if (pend) begin
                idx++;
                if (idx < 256) tx_data = 8'(idx);
                else tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        for (int k = 0; k < FRAME + N; k++) begin
            if (tx_done === 1'b1) nd++;
            tick();
        end
        rx_on = 1'b0;
        total++; if (idx != 256) begin bad++; $display("FAIL lb_accepts got=%0d exp=256", idx); end
        total++; if (rx_frames != 256) begin bad++; $display("FAIL lb_rx_frames got=%0d exp=256", rx_frames); end
        total++; if (nd != 256) begin bad++; $display("FAIL lb_done_pulses got=%0d exp=256", nd); end
        total++; if (rx_err != 0) begin bad++; $display("FAIL lb_rx_framing got=%0d errors exp=0", rx_err); end
        for (int i = 0; i < rx_q.size() && i < 256; i++)
            if (rx_q[i] !== 8'(i)) nbad++;
        total++; if (nbad != 0) begin bad++; $display("FAIL lb_data got=%0d wrong bytes exp=0", nbad); end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        test_no_parity();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
